// File: rtl/sample_player.sv
// Stimulus playback source: samples queued by the bench writer are replayed onto the
// DUT input bus, one per sample period, each accompanied by a single-cycle strobe.
module sample_player #(
   parameter int DATA_WIDTH   = 16,
   parameter int DEPTH        = 16,
   parameter int SAMPLE_FREQ  = 1_000_000,
   parameter int DUT_CLK_FREQ = 50_000_000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [DATA_WIDTH-1:0]   s_data,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic [DATA_WIDTH-1:0]   dut_data,
   output logic                    dut_strobe,
   output logic                    underrun,
   input  logic                    clear_underrun,
   output logic [$clog2(DEPTH):0]  level
);
   localparam int AW  = $clog2(DEPTH);
   localparam int LW  = AW + 1;
   localparam int DIV = (SAMPLE_FREQ > 0) ? DUT_CLK_FREQ / SAMPLE_FREQ : 0;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   generate
      if (SAMPLE_FREQ < 1 || DIV < 1 || DIV * SAMPLE_FREQ != DUT_CLK_FREQ) begin : g_bad_div
         $error("sample_player: DUT_CLK_FREQ/SAMPLE_FREQ must be an integer >= 1");
      end
      if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
         $error("sample_player: DEPTH must be a power of 2 and at least 2");
      end
   endgenerate

   // Sample-period divider; held at zero while disabled so re-enable restarts the period.
   logic [CW-1:0] count_q, count_d;
   logic          tick;

   assign tick = enable && (count_q == CW'(DIV - 1));

   always_comb begin
      count_d = count_q + CW'(1);
      if (!enable || tick) begin
         count_d = '0;
      end
   end

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]         level_q, level_d;
   logic                  push, pop;

   assign s_ready = (level_q != LW'(DEPTH));
   assign push    = s_valid && s_ready;
   assign pop     = tick && (level_q != '0);

   always_comb begin
      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + LW'(1);
      end else if (!push && pop) begin
         level_d = level_q - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= s_data;
      end
   end

   logic [DATA_WIDTH-1:0] dut_data_q;
   logic                  dut_strobe_q;
   logic                  underrun_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         dut_data_q   <= '0;
         dut_strobe_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         count_q      <= count_d;
         level_q      <= level_d;
         dut_strobe_q <= pop;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q   <= rd_ptr_q + AW'(1);
            dut_data_q <= mem_q[rd_ptr_q];
         end
         // A starving tick takes priority over a simultaneous clear.
         if (tick && level_q == '0) begin
            underrun_q <= 1'b1;
         end else if (clear_underrun) begin
            underrun_q <= 1'b0;
         end
      end
   end

   assign dut_data   = dut_data_q;
   assign dut_strobe = dut_strobe_q;
   assign underrun   = underrun_q;
   assign level      = level_q;
endmodule

// File: tb/tb_sample_player.sv
// Bench for sample_player: instance 0 runs at DIV=4, instance 1 at DIV=1; a push-history
// model is compared against both every cycle, plus hand-computed directed expectations.
module tb_sample_player;
   localparam int DW    = 16;
   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]    rst = 2'b11;
   logic [1:0]    en  = 2'b00;
   logic [1:0]    vld = 2'b00;
   logic [1:0]    clr = 2'b00;
   logic [DW-1:0] sdat [2] = '{default: '0};
   logic [1:0]    rdy, stb, und;
   logic [DW-1:0] dat [2];
   logic [LW-1:0] lvl [2];

   sample_player #(.DATA_WIDTH(DW), .DEPTH(DEPTH),
                   .SAMPLE_FREQ(25_000_000), .DUT_CLK_FREQ(100_000_000)) u_div4 (
      .clk(clk), .rst(rst[0]), .enable(en[0]), .s_data(sdat[0]), .s_valid(vld[0]),
      .s_ready(rdy[0]), .dut_data(dat[0]), .dut_strobe(stb[0]), .underrun(und[0]),
      .clear_underrun(clr[0]), .level(lvl[0]));

   sample_player #(.DATA_WIDTH(DW), .DEPTH(DEPTH),
                   .SAMPLE_FREQ(50_000_000), .DUT_CLK_FREQ(50_000_000)) u_div1 (
      .clk(clk), .rst(rst[1]), .enable(en[1]), .s_data(sdat[1]), .s_valid(vld[1]),
      .s_ready(rdy[1]), .dut_data(dat[1]), .dut_strobe(stb[1]), .underrun(und[1]),
      .clear_underrun(clr[1]), .level(lvl[1]));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", name, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Model: a log of every accepted sample; occupancy is pushes minus pops.
   logic [DW-1:0] hist [2][1024];
   int            npush [2];
   int            npop  [2];
   int            mcnt  [2];
   logic [DW-1:0] mdata [2];
   bit            mstb  [2];
   bit            mund  [2];
   bit            m_tick, m_push;
   int            m_div;

   initial begin
      forever begin
         @(posedge clk);
         for (int k = 0; k < 2; k++) begin
            m_div = (k == 0) ? 4 : 1;
            if (rst[k]) begin
               npush[k] = 0; npop[k] = 0; mcnt[k] = 0;
               mdata[k] = '0; mstb[k] = 0; mund[k] = 0;
            end else begin
               m_tick  = en[k] && (mcnt[k] == m_div - 1);
               mcnt[k] = (en[k] && !m_tick) ? mcnt[k] + 1 : 0;
               m_push  = vld[k] && (npush[k] - npop[k] < DEPTH);
               mstb[k] = 0;
               if (clr[k]) mund[k] = 0;
               if (m_tick) begin
                  if (npush[k] > npop[k]) begin
                     mdata[k] = hist[k][npop[k]];
                     npop[k]  = npop[k] + 1;
                     mstb[k]  = 1;
                  end else begin
                     mund[k] = 1;
                  end
               end
               if (m_push) begin
                  hist[k][npush[k]] = sdat[k];
                  npush[k] = npush[k] + 1;
               end
            end
         end
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("model dut%0d dut_data", k), 32'(dat[k]), 32'(mdata[k]));
            chk($sformatf("model dut%0d dut_strobe", k), 32'(stb[k]), 32'(mstb[k]));
            chk($sformatf("model dut%0d underrun", k), 32'(und[k]), 32'(mund[k]));
            chk($sformatf("model dut%0d level", k), 32'(lvl[k]), 32'(npush[k] - npop[k]));
            chk($sformatf("model dut%0d s_ready", k), 32'(rdy[k]),
                32'((npush[k] - npop[k]) != DEPTH));
         end
      end
   end

   int guard;

   initial begin
      step(2);
      rst = 2'b00;
      chk("reset dut_data", 32'(dat[0]), 0);
      chk("reset dut_strobe", 32'(stb[0]), 0);
      chk("reset underrun", 32'(und[0]), 0);
      chk("reset level", 32'(lvl[0]), 0);
      chk("reset s_ready", 32'(rdy[0]), 1);

      // Basic playback at DIV=4
      vld[0] = 1;
      for (int i = 1; i <= 3; i++) begin
         sdat[0] = 16'(i);
         step(1);
      end
      vld[0] = 0;
      chk("basic level", 32'(lvl[0]), 3);
      en[0] = 1;
      for (int i = 1; i <= 3; i++) begin
         step(3);
         chk("basic no early strobe", 32'(stb[0]), 0);
         step(1);
         chk("basic strobe", 32'(stb[0]), 1);
         chk("basic data", 32'(dat[0]), 32'(i));
      end
      en[0] = 0;
      chk("basic underrun", 32'(und[0]), 0);

      // Fill to DEPTH, 17th sample held by the writer
      vld[0] = 1;
      for (int i = 0; i < 16; i++) begin
         sdat[0] = 16'h0100 + 16'(i);
         step(1);
      end
      chk("fill s_ready low", 32'(rdy[0]), 0);
      sdat[0] = 16'h0110;
      step(3);
      chk("fill level", 32'(lvl[0]), 16);
      chk("fill held s_ready", 32'(rdy[0]), 0);
      en[0] = 1;
      step(4);
      chk("fill pop strobe", 32'(stb[0]), 1);
      chk("fill pop data", 32'(dat[0]), 32'h0100);
      chk("fill s_ready back", 32'(rdy[0]), 1);
      chk("fill level after pop", 32'(lvl[0]), 15);
      en[0] = 0;
      step(1);
      vld[0] = 0;
      chk("fill 17th accepted", 32'(lvl[0]), 16);
      en[0] = 1;
      step(64);
      chk("fill drained level", 32'(lvl[0]), 0);
      chk("fill last data", 32'(dat[0]), 32'h0110);
      en[0] = 0;

      // Underrun from reset state, then clear and replay
      rst[0] = 1;
      step(1);
      rst[0] = 0;
      chk("rst dut_data", 32'(dat[0]), 0);
      en[0] = 1;
      step(4);
      chk("underrun set", 32'(und[0]), 1);
      chk("underrun no strobe", 32'(stb[0]), 0);
      chk("underrun data held", 32'(dat[0]), 0);
      vld[0] = 1; sdat[0] = 16'hBEEF;
      step(1);
      vld[0] = 0; clr[0] = 1;
      step(1);
      clr[0] = 0;
      chk("underrun cleared", 32'(und[0]), 0);
      step(2);
      chk("underrun replay strobe", 32'(stb[0]), 1);
      chk("underrun replay data", 32'(dat[0]), 32'hBEEF);
      en[0] = 0;
      step(1);

      // Clear and starving tick on the same edge: set wins
      en[0] = 1; clr[0] = 1;
      step(4);
      chk("set beats clear", 32'(und[0]), 1);
      step(1);
      chk("clear after set", 32'(und[0]), 0);
      clr[0] = 0; en[0] = 0;
      step(1);

      // Push and starving tick on the same edge: no bypass
      en[0] = 1;
      step(3);
      vld[0] = 1; sdat[0] = 16'h1234;
      step(1);
      vld[0] = 0;
      chk("push+tick underrun", 32'(und[0]), 1);
      chk("push+tick no strobe", 32'(stb[0]), 0);
      chk("push+tick level", 32'(lvl[0]), 1);
      clr[0] = 1;
      step(1);
      clr[0] = 0;
      step(3);
      chk("push+tick later strobe", 32'(stb[0]), 1);
      chk("push+tick later data", 32'(dat[0]), 32'h1234);
      en[0] = 0;

      // Streaming at DIV=1
      vld[1] = 1; sdat[1] = 16'd0;
      step(1);
      en[1] = 1;
      for (int i = 1; i < 100; i++) begin
         sdat[1] = 16'(i);
         step(1);
         chk("stream strobe", 32'(stb[1]), 1);
         chk("stream data", 32'(dat[1]), 32'(i - 1));
         chk("stream level", 32'(lvl[1]), 1);
      end
      vld[1] = 0;
      step(1);
      en[1] = 0;
      chk("stream last data", 32'(dat[1]), 99);
      chk("stream no underrun", 32'(und[1]), 0);

      // Mid-run disable and reset
      vld[0] = 1;
      for (int i = 0; i < 5; i++) begin
         sdat[0] = 16'h0050 + 16'(i);
         step(1);
      end
      vld[0] = 0;
      en[0] = 1;
      step(4);
      chk("midrun first data", 32'(dat[0]), 32'h0050);
      en[0] = 0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("midrun disabled strobe", 32'(stb[0]), 0);
      end
      en[0] = 1;
      step(3);
      chk("midrun restart no strobe", 32'(stb[0]), 0);
      step(1);
      chk("midrun restart strobe", 32'(stb[0]), 1);
      chk("midrun restart data", 32'(dat[0]), 32'h0051);
      rst[0] = 1;
      step(1);
      rst[0] = 0; en[0] = 0;
      chk("midrun rst level", 32'(lvl[0]), 0);
      chk("midrun rst data", 32'(dat[0]), 0);
      chk("midrun rst underrun", 32'(und[0]), 0);
      chk("midrun rst strobe", 32'(stb[0]), 0);

      // Wrap-around: 40 samples through a 16-entry FIFO
      en[0] = 1;
      for (int i = 0; i < 40; i++) begin
         sdat[0] = 16'hA000 + 16'(i);
         vld[0] = 1;
         guard = 0;
         while (!rdy[0] && guard < 50) begin
            step(1);
            guard++;
         end
         if (guard >= 50) begin
            checks++;
            errors++;
            $display("FAIL wrap writer timeout got s_ready %0d exp 1", rdy[0]);
         end
         step(1);
      end
      vld[0] = 0;
      step(200);
      chk("wrap drained level", 32'(lvl[0]), 0);
      chk("wrap last data", 32'(dat[0]), 32'hA027);
      en[0] = 0;
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sample_player.md
Name: sample_player

Overview:
- Stimulus-side playback block for the DUT.
- The testbench writer pushes input samples through a valid/ready port into an internal FIFO.
- The block pops one sample per sample period, derived as DUT_CLK_FREQ/SAMPLE_FREQ clock cycles, and drives it onto the DUT input bus with a one-cycle strobe.
- It is the consuming end of the stimulus path; a capture block handles DUT outputs.

Parameters:
- DATA_WIDTH, 16, width of one DUT input sample.
- DEPTH, 16, FIFO entries; power of 2, at least 2.
- SAMPLE_FREQ, 1_000_000, sample playback rate in Hz.
- DUT_CLK_FREQ, 50_000_000, frequency of clk in Hz. DIV = DUT_CLK_FREQ/SAMPLE_FREQ must be an integer of at least 1; elaboration error otherwise.

Ports:
- clk  in  1  DUT clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  playback enable; gates the sample-period divider.
- s_data  in  DATA_WIDTH  sample from the testbench writer.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  FIFO can accept a sample.
- dut_data  out  DATA_WIDTH  current sample applied to the DUT inputs.
- dut_strobe  out  1  one-cycle pulse when dut_data takes a new sample.
- underrun  out  1  sticky flag: a tick occurred with the FIFO empty.
- clear_underrun  in  1  clears underrun.
- level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset:
  - Outputs: dut_data=0, dut_strobe=0, underrun=0, level=0, s_ready=1.
  - Internal state: divider count=0, FIFO pointers=0.
  - Reset mid-operation discards all queued samples.
  - Reset overrides every other input in the same cycle.
- Write side:
  - s_ready = (level != DEPTH), driven combinationally from registered level.
  - A push occurs on an edge where s_valid && s_ready.
  - s_data must be held while s_valid=1 && s_ready=0.
  - A write while full is not accepted. It is not lost; the sender holds it.
- Divider:
  - With enable=1, count runs 0..DIV-1 and wraps to 0.
  - tick = enable && (count == DIV-1).
  - With enable=0, count is forced to 0 and no tick occurs.
  - The first tick is on the DIV-th enabled edge after enable rises.
  - DIV=1 gives a tick every enabled cycle.
- Tick with level>0:
  - Pop the head sample into dut_data, registered, visible the cycle after the tick edge.
  - dut_strobe=1 for exactly that cycle.
- Tick with level=0:
  - No pop; dut_data holds its value; dut_strobe=0; underrun<=1.
- Push and pop on the same edge:
  - level unchanged.
  - Legal at any level including DEPTH-1.
  - At level=DEPTH no push occurs, since s_ready=0, so the pop alone reduces level.
- Push and tick on the same edge with level=0:
  - Underrun is flagged.
  - The pushed sample is played on the next tick; no bypass path exists.
- underrun clearing:
  - Cleared only by rst or clear_underrun.
  - If clear_underrun and an underrunning tick occur on the same edge, the set wins and underrun=1.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap naturally. level tracks full/empty.
- Sample order: samples are played strictly in push order.

Test Plan:
- Basic playback:
  - Stimulus: DIV=4 (SAMPLE_FREQ=25_000_000, DUT_CLK_FREQ=100_000_000). Push 0x0001, 0x0002, 0x0003, then assert enable.
  - Required: dut_strobe pulses 4, 8 and 12 cycles after enable; dut_data reads 1, 2, 3 in order; underrun stays 0.
- Fill:
  - Stimulus: DEPTH=16, enable=0, push 17 samples with s_valid held high.
  - Required: s_ready drops after the 16th push; level=16; the 17th sample is held; after enable and one tick, s_ready=1 and the 17th sample is accepted.
- Underrun:
  - Stimulus: enable with the FIFO empty, then push 0xBEEF and pulse clear_underrun.
  - Required: underrun=1 after the first tick, dut_data stays 0, no strobe; clear_underrun returns underrun to 0; the next tick plays 0xBEEF.
- Streaming at DIV=1:
  - Stimulus: continuous writer pushing 0..99, enable=1.
  - Required: level stays at or below 1; each value appears once, in order; a strobe every cycle after the first sample; no underrun while the writer keeps pace.
- Mid-run interruption:
  - Stimulus: 5 queued samples; deassert enable for 10 cycles, then assert rst for one cycle during playback.
  - Required: no strobes while disabled; the divider restarts so the next tick is DIV cycles after re-enable; rst gives level=0, dut_data=0, underrun=0.
- FIFO wrap-around:
  - Stimulus: push and pop 40 samples at DEPTH=16.
  - Required: output sequence matches the input sequence exactly across pointer wrap.
